// File: rtl/pc_seq_pkg.sv
// Shared types and default parameters for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, REDIRECT, HALTED} pc_state_t;

  localparam int                    PC_WIDTH        = 16;
  localparam int                    PC_STEP         = 2;
  localparam logic [PC_WIDTH-1:0]   PC_RESET_VECTOR = '0;

endpackage

// File: rtl/pc_sequencer_adder.sv
// Modulo-2^n adder shared between the sequential and branch-target paths.
module pc_sequencer_adder #(
  parameter int n = 16
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] sum
);

  // Carry out is intentionally dropped: PC arithmetic wraps.
  assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// PC register and update sequencer: increment, relative branch, absolute jump, stall, halt.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               n            = PC_WIDTH,
  parameter int               STEP         = PC_STEP,
  parameter logic [n-1:0]     RESET_VECTOR = PC_RESET_VECTOR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         stall,
  input  logic         halt,
  input  logic         jump,
  input  logic [n-1:0] jump_target,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_offset,
  input  logic         fetch_ready,
  output logic         fetch_valid,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_link,
  output logic         link_valid,
  output logic         halted
);

  localparam logic [n-1:0] STEP_V     = n'(STEP);
  localparam logic [n-1:0] ALIGN_MASK = ~(STEP_V - n'(1));

  pc_state_t             state_q, state_d;
  logic [n-1:0]          pc_q, pc_d;
  logic signed [n-1:0]   offset_q, offset_d;
  logic [n-1:0]          adder_b;
  logic [n-1:0]          adder_sum;

  // One adder: PC+STEP everywhere except the REDIRECT shadow cycle.
  assign adder_b = (state_q == REDIRECT) ? $unsigned(offset_q) : STEP_V;

  pc_sequencer_adder #(.n(n)) u_adder (
    .a   (pc_q),
    .b   (adder_b),
    .sum (adder_sum)
  );

  assign pc          = pc_q;
  assign pc_link     = adder_sum;
  assign link_valid  = (state_q == FETCH);
  assign fetch_valid = (state_q == FETCH) & ~stall;
  assign halted      = (state_q == HALTED);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    offset_d = offset_q;
    unique case (state_q)
      IDLE: begin
        if (halt)    state_d = HALTED;
        else if (en) state_d = FETCH;
      end
      FETCH: begin
        if (halt) begin
          state_d = HALTED;
        end else if (!en) begin
          state_d = IDLE;
        end else if (jump) begin
          pc_d = jump_target & ALIGN_MASK;
        end else if (branch_taken) begin
          offset_d = branch_offset;
          state_d  = REDIRECT;
        end else if (fetch_valid && fetch_ready) begin
          pc_d = adder_sum;
        end
      end
      REDIRECT: begin
        if (halt) begin
          state_d = HALTED;
        end else begin
          pc_d    = adder_sum & ALIGN_MASK;
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VECTOR;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      offset_q <= offset_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus asynchronous-reset corner sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, stall, halt, jump, branch_taken, fetch_ready;
  logic [15:0] jump_target, branch_offset;
  logic        fetch_valid, link_valid, halted;
  logic [15:0] pc, pc_link;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        en, stall, halt, jump;
    logic [15:0] jt;
    logic        br;
    logic [15:0] off;
    logic        rdy;
    logic        fv, lv, hl;
    logic [15:0] epc;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] cur;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .stall         (stall),
    .halt          (halt),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .pc            (pc),
    .pc_link       (pc_link),
    .link_valid    (link_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic s, input logic h, input logic j,
                     input logic [15:0] jt, input logic br, input logic [15:0] off,
                     input logic rdy, input logic fv, input logic lv, input logic hl,
                     input logic [15:0] epc);
    vec_t v;
    v.en = e; v.stall = s; v.halt = h; v.jump = j; v.jt = jt;
    v.br = br; v.off = off; v.rdy = rdy; v.fv = fv; v.lv = lv; v.hl = hl; v.epc = epc;
    vq.push_back(v);
    cur = epc;
  endtask

  task automatic acc(input int k);
    for (int i = 0; i < k; i++) add(1, 0, 0, 0, 16'h0, 0, 16'h0, 1, 1, 1, 0, cur + 16'd2);
  endtask

  task automatic drive(input vec_t v);
    en = v.en; stall = v.stall; halt = v.halt; jump = v.jump; jump_target = v.jt;
    branch_taken = v.br; branch_offset = v.off; fetch_ready = v.rdy;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".pc"},      pc, 16'h0000);
    check({tag, ".fv"},      {15'd0, fetch_valid}, 16'd0);
    check({tag, ".lv"},      {15'd0, link_valid}, 16'd0);
    check({tag, ".halted"},  {15'd0, halted}, 16'd0);
    check({tag, ".pc_link"}, pc_link, 16'h0002);
  endtask

  initial begin
    vec_t idle_v;
    idle_v = '{en:0, stall:0, halt:0, jump:0, jt:16'h0, br:0, off:16'h0, rdy:0,
               fv:0, lv:0, hl:0, epc:16'h0};
    drive(idle_v);
    rst_n = 1'b0;

    cur = 16'h0000;
    add(1, 0, 0, 0, 16'h0,    0, 16'h0,    1, 1, 1, 0, 16'h0000);
    acc(8);
    add(1, 0, 0, 0, 16'h0,    1, 16'hFFF8, 1, 0, 0, 0, 16'h0010);
    add(1, 0, 0, 1, 16'h4000, 1, 16'h0100, 1, 1, 1, 0, 16'h0008);
    acc(12);
    add(1, 0, 0, 1, 16'h1235, 0, 16'h0,    1, 1, 1, 0, 16'h1234);
    add(1, 0, 0, 1, 16'h0040, 0, 16'h0,    1, 1, 1, 0, 16'h0040);
    for (int i = 0; i < 3; i++)
      add(1, 1, 0, 0, 16'h0,  0, 16'h0,    1, 0, 1, 0, 16'h0040);
    add(1, 0, 0, 0, 16'h0,    0, 16'h0,    1, 1, 1, 0, 16'h0042);
    add(1, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 1, 0, 16'h0042);
    add(1, 0, 0, 1, 16'hFFFF, 0, 16'h0,    0, 1, 1, 0, 16'hFFFE);
    acc(1);
    add(0, 0, 0, 0, 16'h0,    0, 16'h0,    1, 0, 0, 0, 16'h0000);
    add(1, 0, 0, 0, 16'h0,    0, 16'h0,    1, 1, 1, 0, 16'h0000);
    add(1, 0, 1, 1, 16'h5555, 0, 16'h0,    1, 0, 0, 1, 16'h0000);
    add(1, 0, 0, 1, 16'h7777, 1, 16'h0008, 1, 0, 0, 1, 16'h0000);
    add(0, 0, 0, 0, 16'h0,    0, 16'h0,    1, 0, 0, 1, 16'h0000);

    #2;
    check_reset_outputs("init_reset");
    #10 rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk); #1;
      check($sformatf("row%0d.pc", i), pc, vq[i].epc);
      check($sformatf("row%0d.fv", i), {15'd0, fetch_valid}, {15'd0, vq[i].fv});
      check($sformatf("row%0d.lv", i), {15'd0, link_valid}, {15'd0, vq[i].lv});
      check($sformatf("row%0d.halted", i), {15'd0, halted}, {15'd0, vq[i].hl});
      if (vq[i].lv) check($sformatf("row%0d.pc_link", i), pc_link, vq[i].epc + 16'd2);
    end

    // Asynchronous reset while HALTED: outputs clear before any edge.
    rst_n = 1'b0; #1;
    check_reset_outputs("rst_halted");
    #1 rst_n = 1'b1;

    drive(idle_v); en = 1'b1; fetch_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("seq2.pc", pc, 16'h0004);
    branch_taken = 1'b1; branch_offset = 16'h0010;
    @(posedge clk); #1;
    check("seq2.redirect_fv", {15'd0, fetch_valid}, 16'd0);
    check("seq2.redirect_pc", pc, 16'h0004);
    // Asynchronous reset in the REDIRECT shadow cycle.
    #1 rst_n = 1'b0; #1;
    check_reset_outputs("rst_redirect");
    #1 rst_n = 1'b1;
    drive(idle_v);
    @(posedge clk); #1;
    check("post_rst.idle_lv", {15'd0, link_valid}, 16'd0);
    check("post_rst.idle_pc", pc, 16'h0000);
    en = 1'b1;
    @(posedge clk); #1;
    check("post_rst.fetch_lv", {15'd0, link_valid}, 16'd1);
    check("post_rst.fetch_pc", pc, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter controller for the 16-bit core. It owns the PC register and sequences every PC update: sequential increment, relative branch, absolute jump, stall and halt. It time-shares a single adder instance between PC+STEP (sequential/link) and PC+offset (branch target). A valid/ready handshake presents the fetch address to instruction memory.

Parameters:
n, 16, datapath and PC width in bits.
STEP, 2, byte increment per instruction; must be a power of two, at most 2^(n-1).
RESET_VECTOR, 16'h0000, PC value loaded on reset; must be STEP-aligned.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  run enable from the top level.
stall  input  1  pipeline hazard; suppresses fetch.
halt  input  1  enter HALTED; only reset exits.
jump  input  1  absolute redirect request.
jump_target  input  n  jump destination.
branch_taken  input  1  relative redirect request.
branch_offset  input  n  two's-complement byte offset.
fetch_ready  input  1  instruction memory accepts pc.
fetch_valid  output  1  pc is a valid fetch address.
pc  output  n  current fetch address (registered).
pc_link  output  n  pc+STEP; valid only when link_valid=1.
link_valid  output  1  the adder is serving the sequential path this cycle.
halted  output  1  the FSM is in HALTED.

Behaviour:
- Reset (asynchronous, also mid-operation) sets:
  - pc=RESET_VECTOR, state=IDLE, offset_q=0.
  - fetch_valid=0, link_valid=0, halted=0.
  - pc_link=RESET_VECTOR+STEP (combinational, ignored while link_valid=0).
- States: IDLE, FETCH, REDIRECT, HALTED.
- IDLE:
  - fetch_valid=0. Redirect inputs are ignored.
  - halt goes to HALTED; otherwise en=1 goes to FETCH on the next edge.
- FETCH:
  - fetch_valid = ~stall; link_valid=1; adder operands are (pc, STEP).
  - Priority per cycle:
    1. halt: go to HALTED, pc holds.
    2. en=0: go to IDLE, pc holds.
    3. jump: pc <= jump_target with the low log2(STEP) bits forced to 0; stay in FETCH.
    4. branch_taken: offset_q <= branch_offset; go to REDIRECT; pc holds.
    5. fetch_valid & fetch_ready: pc <= adder sum (pc+STEP).
    6. Otherwise pc holds.
  - Redirects are honoured even while stall=1.
  - A handshake coinciding with a redirect is discarded; the redirect wins.
- REDIRECT (exactly one cycle):
  - fetch_valid=0, link_valid=0; adder operands are (pc, offset_q).
  - halt goes to HALTED. Otherwise pc <= sum with the low log2(STEP) bits forced to 0, then FETCH.
  - Branch and jump inputs are ignored in this cycle (shadow cycle; the decoder must not issue them).
- HALTED: fetch_valid=0, halted=1, pc holds; all inputs are ignored until rst_n.
- Arithmetic:
  - Additions are modulo 2^n; the carry is dropped and there is no overflow flag.
  - Wrap example: pc=16'hFFFE, STEP=2 gives 16'h0000.
  - Negative offsets wrap the same way.
- Latency:
  - Sequential advance: pc updates on the edge of the accepting handshake.
  - Jump: 1 cycle.
  - Branch: 2 cycles from branch_taken to the first valid fetch at the target.
- fetch_ready with fetch_valid=0 has no effect. fetch_valid never depends combinationally on fetch_ready.
- Only the pc_link/link_valid path is combinational from pc; all other outputs are registered or decoded from state and stall.

Decomposition:
- Package pc_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, FETCH, REDIRECT, HALTED} pc_state_t;
  - localparam defaults PC_WIDTH=16, PC_STEP=2, PC_RESET_VECTOR='0.
- Sub-module: one instance of the existing adder (parameter n). pc_sequencer muxes its b operand between STEP and offset_q by state.
- No other sub-modules.

Test Plan:
- Reset, en=1, fetch_ready=1 held, STEP=2: pc sequence 0000, 0002, 0004, 0006 on consecutive edges; fetch_valid=1 from the second cycle after en.
- At pc=0010, branch_taken with offset=FFF8 (-8): REDIRECT for one cycle with fetch_valid=0, then pc=0008 and fetch_valid=1; branch inputs during REDIRECT have no effect.
- At pc=0020, jump=1 with jump_target=1235, fetch_ready=1 in the same cycle: next pc=1234, not 0022.
- stall=1 for 3 cycles at pc=0040 with fetch_ready=1: fetch_valid=0 and pc=0040 throughout; stall then drops and pc advances to 0042 on the next accept.
- pc=FFFE with an accept: pc=0000. halt together with jump: HALTED, halted=1, pc unchanged; further en/jump are ignored.
- rst_n asserted in REDIRECT and then in HALTED: outputs are at reset values immediately, before any clock edge; after release, IDLE and pc=RESET_VECTOR.
